// File: rtl/ttt_board_engine_if.sv
// rtl/ttt_board_engine_if.sv - turn-grant / move / status bundle between turn controller and board engine
//
// Signals:
//   player1_turn, player2_turn  turn grant levels from the controller
//   p1_pos, p2_pos              target cells, 0..8 row-major
//   illegal_move                current grant carries an illegal move
//   no_space                    all 9 cells occupied
//   winner, who_won             line complete / owner (00 none, 01 P1, 10 P2)
// Modports: master = controller/move-source side, slave = board engine.

interface ttt_board_engine_if;
    logic       player1_turn;
    logic       player2_turn;
    logic [3:0] p1_pos;
    logic [3:0] p2_pos;
    logic       illegal_move;
    logic       no_space;
    logic       winner;
    logic [1:0] who_won;

    modport master (
        output player1_turn, player2_turn, p1_pos, p2_pos,
        input  illegal_move, no_space, winner, who_won
    );

    modport slave (
        input  player1_turn, player2_turn, p1_pos, p2_pos,
        output illegal_move, no_space, winner, who_won
    );
endinterface

// File: rtl/ttt_board_engine.sv
// rtl/ttt_board_engine.sv - tic-tac-toe board store, move legality and win/draw detection
//
// Ports:
//   clk, reset      clock / asynchronous active-high reset
//   new_game        synchronous clear of board, move count and grant history
//   bus (slave)     turn grants, move positions, illegal_move/no_space/winner/who_won
//   board           cell i = board[2i+1:2i]; 00 empty, 01 P1, 10 P2
//   move_count      legal moves applied this game, 0..9
//   p1_score,
//   p2_score        games won per player (only when TTT_SCORE_EN is defined)
// Optional feature macro: TTT_SCORE_EN (per-player saturating win counters, width SCORE_W).

module ttt_board_engine #(
    parameter int SCORE_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_game,
    ttt_board_engine_if.slave   bus,
    output logic [17:0]         board,
    output logic [3:0]          move_count
`ifdef TTT_SCORE_EN
    ,
    output logic [SCORE_W-1:0]  p1_score,
    output logic [SCORE_W-1:0]  p2_score
`endif
);

    logic [17:0] board_q;
    logic [3:0]  count_q;
    logic        p1_turn_q;
    logic        p2_turn_q;

    logic        p1_edge;
    logic        p2_edge;
    logic [3:0]  req_pos;
    logic [31:0] board_ext;
    logic [1:0]  req_cell;
    logic        legal;
    logic [1:0]  mark;
    logic        p1_line;
    logic        p2_line;
    logic        winner_c;
    logic        no_space_c;

    function automatic logic [1:0] cell_at(input logic [17:0] b, input int i);
        return b[2*i +: 2];
    endfunction

    function automatic logic line3(input logic [17:0] b, input int a, input int m, input int c,
                                   input logic [1:0] p);
        return (cell_at(b, a) == p) && (cell_at(b, m) == p) && (cell_at(b, c) == p);
    endfunction

    function automatic logic has_line(input logic [17:0] b, input logic [1:0] p);
        return line3(b, 0, 1, 2, p) || line3(b, 3, 4, 5, p) || line3(b, 6, 7, 8, p) ||
               line3(b, 0, 3, 6, p) || line3(b, 1, 4, 7, p) || line3(b, 2, 5, 8, p) ||
               line3(b, 0, 4, 8, p) || line3(b, 2, 4, 6, p);
    endfunction

    always_comb begin
        // A grant is a request only in the cycle its level first rises.
        p1_edge    = bus.player1_turn & ~p1_turn_q;
        p2_edge    = bus.player2_turn & ~p2_turn_q;
        req_pos    = p1_edge ? bus.p1_pos : bus.p2_pos;
        // Zero-extended copy so positions 9..15 index harmlessly; they are rejected below anyway.
        board_ext  = {14'd0, board_q};
        req_cell   = board_ext[{req_pos, 1'b0} +: 2];
        mark       = p1_edge ? 2'b01 : 2'b10;

        p1_line    = has_line(board_q, 2'b01);
        p2_line    = has_line(board_q, 2'b10);
        winner_c   = p1_line | p2_line;
        no_space_c = (count_q == 4'd9);

        // Simultaneous edges from both players are rejected outright.
        legal = (p1_edge ^ p2_edge) && (req_pos <= 4'd8) && (req_cell == 2'b00) &&
                !winner_c && !no_space_c && !new_game;

        bus.illegal_move = (p1_edge | p2_edge) & ~legal & ~new_game;
        bus.no_space     = no_space_c;
        bus.winner       = winner_c;
        bus.who_won      = p1_line ? 2'b01 : (p2_line ? 2'b10 : 2'b00);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            board_q   <= '0;
            count_q   <= '0;
            p1_turn_q <= 1'b0;
            p2_turn_q <= 1'b0;
        end else if (new_game) begin
            board_q   <= '0;
            count_q   <= '0;
            p1_turn_q <= 1'b0;
            p2_turn_q <= 1'b0;
        end else begin
            p1_turn_q <= bus.player1_turn;
            p2_turn_q <= bus.player2_turn;
            if (legal) begin
                for (int i = 0; i < 9; i++) begin
                    if (req_pos == i[3:0]) begin
                        board_q[2*i +: 2] <= mark;
                    end
                end
                // legal excludes a full board, so this never passes 9.
                count_q <= count_q + 4'd1;
            end
        end
    end

    assign board      = board_q;
    assign move_count = count_q;

`ifdef TTT_SCORE_EN
    logic               winner_q;
    logic [SCORE_W-1:0] p1_score_q;
    logic [SCORE_W-1:0] p2_score_q;

    // winner_q tracks the decoded winner so the score bumps once, on the first
    // cycle the completed line is visible; scores survive new_game.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            winner_q   <= 1'b0;
            p1_score_q <= '0;
            p2_score_q <= '0;
        end else begin
            winner_q <= winner_c;
            if (winner_c && !winner_q) begin
                if (p1_line && (p1_score_q != '1)) begin
                    p1_score_q <= p1_score_q + 1'b1;
                end else if (!p1_line && p2_line && (p2_score_q != '1)) begin
                    p2_score_q <= p2_score_q + 1'b1;
                end
            end
        end
    end

    assign p1_score = p1_score_q;
    assign p2_score = p2_score_q;
`endif

endmodule

// File: tb/tb_ttt_board_engine.sv
// tb/tb_ttt_board_engine.sv - directed self-checking bench for ttt_board_engine

module tb_ttt_board_engine;

    logic        clk;
    logic        reset;
    logic        new_game;
    logic [17:0] board;
    logic [3:0]  move_count;
`ifdef TTT_SCORE_EN
    logic [1:0]  p1_score;
    logic [1:0]  p2_score;
`endif

    int n_checks;
    int n_fails;

    ttt_board_engine_if bus ();

    ttt_board_engine #(.SCORE_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .new_game   (new_game),
        .bus        (bus.slave),
        .board      (board),
        .move_count (move_count)
`ifdef TTT_SCORE_EN
        ,
        .p1_score   (p1_score),
        .p2_score   (p2_score)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One grant: raise the turn at a negedge, check illegal_move mid-cycle,
    // let one rising edge pass, then drop the grant.
    task automatic move(input int player, input logic [3:0] pos, input logic exp_illegal,
                        input string tag);
        @(negedge clk);
        if (player == 1) begin
            bus.player1_turn = 1'b1;
            bus.p1_pos       = pos;
        end else begin
            bus.player2_turn = 1'b1;
            bus.p2_pos       = pos;
        end
        #1;
        chk(tag, {31'd0, bus.illegal_move}, {31'd0, exp_illegal});
        @(posedge clk);
        @(negedge clk);
        bus.player1_turn = 1'b0;
        bus.player2_turn = 1'b0;
    endtask

    task automatic start_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    initial begin
        n_checks         = 0;
        n_fails          = 0;
        reset            = 1'b1;
        new_game         = 1'b0;
        bus.player1_turn = 1'b0;
        bus.player2_turn = 1'b0;
        bus.p1_pos       = 4'd0;
        bus.p2_pos       = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_board", {14'd0, board}, 32'd0);
        chk("reset_count", {28'd0, move_count}, 32'd0);
        chk("reset_illegal", {31'd0, bus.illegal_move}, 32'd0);
        chk("reset_no_space", {31'd0, bus.no_space}, 32'd0);
        chk("reset_winner", {31'd0, bus.winner}, 32'd0);
        chk("reset_who_won", {30'd0, bus.who_won}, 32'd0);
        reset = 1'b0;

        // First move and occupied / out-of-range rejections.
        move(1, 4'd4, 1'b0, "p1_pos4_legal");
        chk("p1_pos4_board", {14'd0, board}, 32'h100);
        chk("p1_pos4_count", {28'd0, move_count}, 32'd1);
        move(2, 4'd4, 1'b1, "p2_occupied_illegal");
        chk("p2_occupied_board", {14'd0, board}, 32'h100);
        chk("p2_occupied_count", {28'd0, move_count}, 32'd1);
        chk("illegal_one_cycle", {31'd0, bus.illegal_move}, 32'd0);
        move(2, 4'd9, 1'b1, "p2_pos9_illegal");
        chk("p2_pos9_count", {28'd0, move_count}, 32'd1);

        // P1 wins the top row.
        start_new_game();
        chk("ng_board", {14'd0, board}, 32'd0);
        move(1, 4'd0, 1'b0, "win_m1");
        move(2, 4'd3, 1'b0, "win_m2");
        move(1, 4'd1, 1'b0, "win_m3");
        move(2, 4'd4, 1'b0, "win_m4");
        chk("win_not_yet", {31'd0, bus.winner}, 32'd0);
        move(1, 4'd2, 1'b0, "win_m5");
        chk("win_winner", {31'd0, bus.winner}, 32'd1);
        chk("win_who_won", {30'd0, bus.who_won}, 32'd1);
        chk("win_board", {14'd0, board}, 32'h295);
        move(2, 4'd5, 1'b1, "after_win_illegal");
        chk("after_win_board", {14'd0, board}, 32'h295);
        chk("after_win_count", {28'd0, move_count}, 32'd5);

        // Draw: X0 O1 X2 X3 O4 O5 O6 X7 X8.
        start_new_game();
        move(1, 4'd0, 1'b0, "draw_m1");
        move(2, 4'd1, 1'b0, "draw_m2");
        move(1, 4'd2, 1'b0, "draw_m3");
        move(1, 4'd3, 1'b0, "draw_m4");
        move(2, 4'd4, 1'b0, "draw_m5");
        move(2, 4'd5, 1'b0, "draw_m6");
        move(2, 4'd6, 1'b0, "draw_m7");
        move(1, 4'd7, 1'b0, "draw_m8");
        chk("draw_space_left", {31'd0, bus.no_space}, 32'd0);
        move(1, 4'd8, 1'b0, "draw_m9");
        chk("draw_count", {28'd0, move_count}, 32'd9);
        chk("draw_no_space", {31'd0, bus.no_space}, 32'd1);
        chk("draw_winner", {31'd0, bus.winner}, 32'd0);
        chk("draw_who_won", {30'd0, bus.who_won}, 32'd0);
        chk("draw_board", {14'd0, board}, 32'h16A59);
        move(2, 4'd0, 1'b1, "full_illegal");
        chk("full_count", {28'd0, move_count}, 32'd9);

        // Held grant applies exactly one move.
        start_new_game();
        @(negedge clk);
        bus.player2_turn = 1'b1;
        bus.p2_pos       = 4'd6;
        #1;
        chk("hold_first_illegal", {31'd0, bus.illegal_move}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("hold_second_illegal", {31'd0, bus.illegal_move}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("hold_count", {28'd0, move_count}, 32'd1);
        chk("hold_board", {14'd0, board}, 32'h2000);
        bus.player2_turn = 1'b0;

        // new_game beats a simultaneous P1 edge.
        @(negedge clk);
        bus.player1_turn = 1'b1;
        bus.p1_pos       = 4'd0;
        new_game         = 1'b1;
        #1;
        chk("ng_edge_illegal", {31'd0, bus.illegal_move}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        new_game         = 1'b0;
        bus.player1_turn = 1'b0;
        chk("ng_edge_board", {14'd0, board}, 32'd0);
        chk("ng_edge_count", {28'd0, move_count}, 32'd0);

        // Both grants rising together is illegal.
        @(negedge clk);
        bus.player1_turn = 1'b1;
        bus.player2_turn = 1'b1;
        bus.p1_pos       = 4'd1;
        bus.p2_pos       = 4'd2;
        #1;
        chk("both_edges_illegal", {31'd0, bus.illegal_move}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.player1_turn = 1'b0;
        bus.player2_turn = 1'b0;
        chk("both_edges_count", {28'd0, move_count}, 32'd0);

`ifdef TTT_SCORE_EN
        // Four P2 wins on the top row; a 2-bit score saturates at 3.
        for (int g = 1; g <= 4; g++) begin
            start_new_game();
            move(1, 4'd3, 1'b0, "sc_m1");
            move(2, 4'd0, 1'b0, "sc_m2");
            move(1, 4'd4, 1'b0, "sc_m3");
            move(2, 4'd1, 1'b0, "sc_m4");
            move(1, 4'd8, 1'b0, "sc_m5");
            move(2, 4'd2, 1'b0, "sc_m6");
            @(negedge clk);
            chk("sc_who_won", {30'd0, bus.who_won}, 32'd2);
            chk("sc_p2_score", {30'd0, p2_score}, (g > 3) ? 32'd3 : g);
            chk("sc_p1_score", {30'd0, p1_score}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("sc_reset_p2", {30'd0, p2_score}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
